pulse_burst_decoder: RTL and testbench

Receive-side counterpart to the team's burst pulse generator. Samples a synchronous per-cycle pulse qualifier plus end-of-burst flag, counts pulses in each burst, and hands the completed count to a consumer over a valid/ready interface. Bursts end on an explicit last flag or on an idle-gap timeout. Sits between the pulse-train source and any block that must know how many pulses were actually delivered.

---
 rtl/pulse_burst_decoder.sv | 152 +++++++++++++++
 tb/tb_pulse_burst_decoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_decoder.sv
// Counts pulses per burst (ended by last_in or an idle-gap timeout) and offers
// each completed count to a consumer through a one-entry valid/ready register.
module pulse_burst_decoder #(
  parameter int CNT_W     = 4,
  parameter int GAP_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             last_in,
  input  logic             clear_err,
  output logic [CNT_W-1:0] count_out,
  output logic             sat_out,
  output logic             gap_err_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             burst_active,
  output logic             drop_err
);

  localparam int GAP_W = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sat_q, sat_d;

  logic             done;
  logic [CNT_W-1:0] doneCnt;
  logic             doneSat;
  logic             doneGap;

  logic [CNT_W-1:0] resCnt_q;
  logic             resSat_q;
  logic             resGap_q;
  logic             valid_q;
  logic             drop_q;

  logic             loadRes;
  logic             dropRes;

  // Burst tracking; a completing burst returns to IDLE so the next cycle can start a new one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sat_d   = sat_q;
    done    = 1'b0;
    doneCnt = cnt_q;
    doneSat = sat_q;
    doneGap = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          cnt_d = CNT_ONE;
          gap_d = '0;
          sat_d = 1'b0;
          if (last_in) begin
            done    = 1'b1;
            doneCnt = CNT_ONE;
            doneSat = 1'b0;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (pulse_in) begin
          gap_d = '0;
          if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (last_in) begin
            done    = 1'b1;
            doneCnt = cnt_d;
            doneSat = sat_d;
            state_d = IDLE;
          end
        end else if (gap_q == GAP_LAST) begin
          done    = 1'b1;
          doneGap = 1'b1;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sat_q   <= sat_d;
    end
  end

  // A result may replace the held one in the same cycle the consumer takes it.
  assign loadRes = done && (!valid_q || count_ready);
  assign dropRes = done && valid_q && !count_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resCnt_q <= '0;
      resSat_q <= 1'b0;
      resGap_q <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (loadRes) begin
        resCnt_q <= doneCnt;
        resSat_q <= doneSat;
        resGap_q <= doneGap;
        valid_q  <= 1'b1;
      end else if (valid_q && count_ready) begin
        valid_q <= 1'b0;
      end
      if (dropRes) begin
        drop_q <= 1'b1;
      end else if (clear_err) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign count_out    = resCnt_q;
  assign sat_out      = resSat_q;
  assign gap_err_out  = resGap_q;
  assign count_valid  = valid_q;
  assign burst_active = (state_q == COUNT);
  assign drop_err     = drop_q;

endmodule

// File: tb/tb_pulse_burst_decoder.sv
// Self-checking bench for pulse_burst_decoder: directed table, corner sequences,
// then random traffic against a pulse-counting reference model.
module tb_pulse_burst_decoder;

  localparam int CNT_W     = 4;
  localparam int GAP_LIMIT = 4;
  localparam int CNT_MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic             last_in = 1'b0;
  logic             clear_err = 1'b0;
  logic             count_ready = 1'b0;
  logic [CNT_W-1:0] count_out;
  logic             sat_out;
  logic             gap_err_out;
  logic             count_valid;
  logic             burst_active;
  logic             drop_err;

  always #5 clk = ~clk;

  pulse_burst_decoder #(
    .CNT_W    (CNT_W),
    .GAP_LIMIT(GAP_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse_in    (pulse_in),
    .last_in     (last_in),
    .clear_err   (clear_err),
    .count_out   (count_out),
    .sat_out     (sat_out),
    .gap_err_out (gap_err_out),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .burst_active(burst_active),
    .drop_err    (drop_err)
  );

  int total = 0;
  int bad = 0;

  // Reference model: real pulse and idle counts, result held as plain integers.
  bit mInBurst;
  int mPulses;
  int mIdle;
  bit mValid;
  int mCount;
  bit mSat;
  bit mGap;
  bit mDrop;

  typedef struct {
    bit p;
    bit l;
    bit c;
    bit r;
    int expCnt;
    bit expSat;
    bit expGap;
    bit expValid;
    bit expActive;
    bit expDrop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit p, bit l, bit c, bit r, int cnt, bit sat, bit gap,
                              bit vld, bit act, bit drp);
    vec_t v;
    v.p = p; v.l = l; v.c = c; v.r = r;
    v.expCnt = cnt; v.expSat = sat; v.expGap = gap;
    v.expValid = vld; v.expActive = act; v.expDrop = drp;
    return v;
  endfunction

  task automatic modelReset();
    mInBurst = 0; mPulses = 0; mIdle = 0;
    mValid = 0; mCount = 0; mSat = 0; mGap = 0; mDrop = 0;
  endtask

  task automatic modelStep(bit p, bit l, bit c, bit r);
    bit done = 0;
    bit dGap = 0;
    int total_pulses = 0;
    if (!mInBurst) begin
      if (p) begin
        mPulses = 1;
        mIdle = 0;
        if (l) done = 1;
        else mInBurst = 1;
      end
    end else if (p) begin
      mPulses++;
      mIdle = 0;
      if (l) begin
        done = 1;
        mInBurst = 0;
      end
    end else begin
      mIdle++;
      if (mIdle == GAP_LIMIT) begin
        done = 1;
        dGap = 1;
        mInBurst = 0;
      end
    end
    total_pulses = mPulses;
    if (done && mValid && !r) begin
      mDrop = 1;
    end else begin
      if (done) begin
        mCount = (total_pulses > CNT_MAXV) ? CNT_MAXV : total_pulses;
        mSat = (total_pulses > CNT_MAXV);
        mGap = dGap;
        mValid = 1;
      end else if (mValid && r) begin
        mValid = 0;
      end
      if (c) mDrop = 0;
    end
  endtask

  task automatic checkVal(string name, logic [31:0] act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkVal({tag, ".count"}, 32'(count_out), mCount);
    checkVal({tag, ".sat"}, 32'(sat_out), int'(mSat));
    checkVal({tag, ".gap"}, 32'(gap_err_out), int'(mGap));
    checkVal({tag, ".valid"}, 32'(count_valid), int'(mValid));
    checkVal({tag, ".active"}, 32'(burst_active), int'(mInBurst));
    checkVal({tag, ".drop"}, 32'(drop_err), int'(mDrop));
  endtask

  // Drives one cycle of inputs, advances the model at the edge, checks at the falling edge.
  task automatic applyStimulus(bit p, bit l, bit c, bit r, string tag);
    pulse_in = p;
    last_in = l;
    clear_err = c;
    count_ready = r;
    @(posedge clk);
    modelStep(p, l, c, r);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic doReset();
    pulse_in = 0; last_in = 0; clear_err = 0; count_ready = 0;
    #2 rst_n = 0;
    modelReset();
    #1 checkOutput("inReset");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int pPulse;
    int pReady;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1;

    // 5-pulse burst with last
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 5, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
    // back-to-back bursts of 4 and 2
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 4, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    // 3 pulses then gap timeout
    tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 0, 0, 0));
    // 1-pulse burst, held while not ready
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // ready low: burst of 2 then 3 is dropped, then clear and drain
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].p, tbl[i].l, tbl[i].c, tbl[i].r, "tblModel");
      checkVal($sformatf("tbl%0d.count", i), 32'(count_out), tbl[i].expCnt);
      checkVal($sformatf("tbl%0d.sat", i), 32'(sat_out), int'(tbl[i].expSat));
      checkVal($sformatf("tbl%0d.gap", i), 32'(gap_err_out), int'(tbl[i].expGap));
      checkVal($sformatf("tbl%0d.valid", i), 32'(count_valid), int'(tbl[i].expValid));
      checkVal($sformatf("tbl%0d.active", i), 32'(burst_active), int'(tbl[i].expActive));
      checkVal($sformatf("tbl%0d.drop", i), 32'(drop_err), int'(tbl[i].expDrop));
    end

    // Saturation boundary: 15 fits, 16 and 20 saturate
    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 0) ? 15 : (k == 1) ? 16 : 20;
      for (int j = 0; j < n - 1; j++) applyStimulus(1, 0, 0, 1, "satRun");
      applyStimulus(1, 1, 0, 1, "satEnd");
      checkVal($sformatf("sat%0d.count", n), 32'(count_out), (n > CNT_MAXV) ? CNT_MAXV : n);
      checkVal($sformatf("sat%0d.flag", n), 32'(sat_out), (n > CNT_MAXV) ? 1 : 0);
      applyStimulus(0, 0, 0, 1, "satDrain");
    end

    // Back-to-back single-pulse results replace each other while ready is high
    applyStimulus(1, 1, 0, 1, "repl1");
    applyStimulus(1, 1, 0, 1, "repl2");
    checkVal("repl.valid", 32'(count_valid), 1);
    applyStimulus(0, 0, 0, 1, "replDrain");
    checkVal("repl.drained", 32'(count_valid), 0);

    // Drop set wins over a same-cycle clear
    applyStimulus(1, 1, 0, 0, "prio1");
    applyStimulus(1, 1, 1, 0, "prio2");
    checkVal("dropPrio", 32'(drop_err), 1);
    applyStimulus(0, 0, 1, 1, "prioClr");
    checkVal("dropCleared", 32'(drop_err), 0);

    // Reset mid-burst discards the partial count
    applyStimulus(1, 0, 0, 1, "mid1");
    applyStimulus(1, 0, 0, 1, "mid2");
    applyStimulus(1, 0, 0, 1, "mid3");
    doReset();
    applyStimulus(0, 0, 0, 1, "postReset");
    checkVal("postReset.valid", 32'(count_valid), 0);
    applyStimulus(1, 1, 0, 0, "oneShot");
    checkVal("oneShot.count", 32'(count_out), 1);
    checkVal("oneShot.valid", 32'(count_valid), 1);
    applyStimulus(0, 0, 0, 1, "oneShotDrain");

    // Random traffic against the model
    pPulse = 70;
    pReady = 60;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: pPulse = 30;
          1: pPulse = 70;
          default: pPulse = 95;
        endcase
        case ($urandom_range(0, 2))
          0: pReady = 20;
          1: pReady = 60;
          default: pReady = 100;
        endcase
      end
      if ($urandom_range(0, 999) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 99) < pPulse, $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 5, $urandom_range(0, 99) < pReady, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
